// File: rtl/ysyx_22050019_axi_pkg.sv
// Shared types and constants for the AXI4-Lite SRAM responder:
// response codes, FSM encodings, bus widths and the address window check.
package ysyx_22050019_axi_pkg;

  localparam int unsigned DATA_W = 64;
  localparam int unsigned ADDR_W = 32;
  localparam int unsigned STRB_W = DATA_W / 8;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic [1:0] {
    W_IDLE = 2'd0,
    W_DATA = 2'd1,
    W_RESP = 2'd2
  } wr_state_e;

  typedef enum logic [1:0] {
    R_IDLE = 2'd0,
    R_WAIT = 2'd1,
    R_RESP = 2'd2
  } rd_state_e;

  // Offset is taken modulo 2^32, so addresses below the base wrap to huge offsets.
  function automatic logic addr_in_range(input logic [ADDR_W-1:0] addr,
                                         input logic [ADDR_W-1:0] base,
                                         input logic [ADDR_W-1:0] span);
    logic [ADDR_W-1:0] off;
    off = addr - base;
    return off < span;
  endfunction

endpackage

// File: rtl/ysyx_22050019_axi_sram_if.sv
// AXI4-Lite style bus between the LSU (master) and the SRAM responder (slave).
// A transfer happens on every rising clk edge where both valid and ready are 1;
// a master holds valid and its payload stable until ready, and never waits for ready to raise valid.
interface ysyx_22050019_axi_sram_if;
  import ysyx_22050019_axi_pkg::*;

  logic              s_axi_aw_valid;
  logic              s_axi_aw_ready;
  logic [ADDR_W-1:0] ram_waddr;
  logic              s_axi_w_valid;
  logic              s_axi_w_ready;
  logic [DATA_W-1:0] ram_wdata;
  logic [STRB_W-1:0] wmask;
  logic              s_axi_b_valid;
  logic              s_axi_b_ready;
  logic [1:0]        ram_wresp_o;
  logic              s_axi_ar_valid;
  logic              s_axi_ar_ready;
  logic [ADDR_W-1:0] ram_raddr;
  logic              s_axi_r_valid;
  logic              s_axi_r_ready;
  logic [DATA_W-1:0] ram_rdata_o;
  logic [1:0]        s_axi_r_resp;

  modport slave (
    input  s_axi_aw_valid, ram_waddr,
    output s_axi_aw_ready,
    input  s_axi_w_valid, ram_wdata, wmask,
    output s_axi_w_ready,
    output s_axi_b_valid, ram_wresp_o,
    input  s_axi_b_ready,
    input  s_axi_ar_valid, ram_raddr,
    output s_axi_ar_ready,
    output s_axi_r_valid, ram_rdata_o, s_axi_r_resp,
    input  s_axi_r_ready
  );

  modport master (
    output s_axi_aw_valid, ram_waddr,
    input  s_axi_aw_ready,
    output s_axi_w_valid, ram_wdata, wmask,
    input  s_axi_w_ready,
    input  s_axi_b_valid, ram_wresp_o,
    output s_axi_b_ready,
    output s_axi_ar_valid, ram_raddr,
    input  s_axi_ar_ready,
    input  s_axi_r_valid, ram_rdata_o, s_axi_r_resp,
    output s_axi_r_ready
  );

endinterface

// File: rtl/ysyx_22050019_sram_array.sv
// DEPTH x 64 storage: one byte-masked synchronous write port, one combinational
// read port, and a backdoor word-load port used to seed contents from the bench.
module ysyx_22050019_sram_array
  import ysyx_22050019_axi_pkg::*;
#(
  parameter int unsigned DEPTH = 4096,
  localparam int unsigned AW   = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              we_i,
  input  logic [AW-1:0]     widx_i,
  input  logic [DATA_W-1:0] wdata_i,
  input  logic [STRB_W-1:0] wmask_i,
  input  logic [AW-1:0]     ridx_i,
  output logic [DATA_W-1:0] rdata_o,
  input  logic              bd_we_i,
  input  logic [AW-1:0]     bd_idx_i,
  input  logic [DATA_W-1:0] bd_data_i
);

  logic [DATA_W-1:0] mem_q [DEPTH];

  // Contents are deliberately not reset; the backdoor load wins over a bus write.
  always_ff @(posedge clk) begin
    if (bd_we_i) begin
      mem_q[bd_idx_i] <= bd_data_i;
    end else if (we_i) begin
      for (int b = 0; b < STRB_W; b++) begin
        if (wmask_i[b]) mem_q[widx_i][8*b +: 8] <= wdata_i[8*b +: 8];
      end
    end
  end

  assign rdata_o = mem_q[ridx_i];

endmodule

// File: rtl/ysyx_22050019_axi_sram.sv
// AXI4-Lite style single-beat SRAM responder with independent read and write FSMs,
// configurable read latency and SLVERR for accesses outside the BASE_ADDR window.
module ysyx_22050019_axi_sram
  import ysyx_22050019_axi_pkg::*;
#(
  parameter int unsigned       DEPTH     = 4096,
  parameter logic [ADDR_W-1:0] BASE_ADDR = 32'h8000_0000,
  parameter int unsigned       RD_LAT    = 1,
  localparam int unsigned      AW        = $clog2(DEPTH)
) (
  input  logic                     clk,
  input  logic                     rst,
  ysyx_22050019_axi_sram_if.slave  s_axi,
  input  logic                     bd_we_i,
  input  logic [AW-1:0]            bd_idx_i,
  input  logic [DATA_W-1:0]        bd_data_i,
  output wr_state_e                wr_state_o,
  output rd_state_e                rd_state_o
);

  localparam logic [ADDR_W-1:0] SPAN = ADDR_W'(DEPTH * 8);

  logic [ADDR_W-1:0] w_off, r_off;
  logic [AW-1:0]     aw_idx, ar_idx;
  logic              aw_ok, ar_ok;
  logic [DATA_W-1:0] arr_rdata;
  logic              mem_we;

  assign w_off  = s_axi.ram_waddr - BASE_ADDR;
  assign r_off  = s_axi.ram_raddr - BASE_ADDR;
  assign aw_idx = AW'(w_off >> 3);
  assign ar_idx = AW'(r_off >> 3);
  assign aw_ok  = addr_in_range(s_axi.ram_waddr, BASE_ADDR, SPAN);
  assign ar_ok  = addr_in_range(s_axi.ram_raddr, BASE_ADDR, SPAN);

  // Holds both address readies low during reset and for the first edge after release.
  logic live_q;
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) live_q <= 1'b0;
    else      live_q <= 1'b1;
  end

  // ---------------- write channel ----------------
  wr_state_e     w_state_q, w_state_d;
  logic [AW-1:0] w_idx_q, w_idx_d;
  logic          w_ok_q, w_ok_d;
  logic [1:0]    b_resp_q, b_resp_d;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      w_state_q <= W_IDLE;
      w_idx_q   <= '0;
      w_ok_q    <= 1'b0;
      b_resp_q  <= RESP_OKAY;
    end else begin
      w_state_q <= w_state_d;
      w_idx_q   <= w_idx_d;
      w_ok_q    <= w_ok_d;
      b_resp_q  <= b_resp_d;
    end
  end

  always_comb begin
    w_state_d = w_state_q;
    w_idx_d   = w_idx_q;
    w_ok_d    = w_ok_q;
    b_resp_d  = b_resp_q;
    mem_we    = 1'b0;
    case (w_state_q)
      W_IDLE: if (live_q && s_axi.s_axi_aw_valid) begin
        w_idx_d   = aw_idx;
        w_ok_d    = aw_ok;
        w_state_d = W_DATA;
      end
      W_DATA: if (s_axi.s_axi_w_valid) begin
        mem_we    = w_ok_q;
        b_resp_d  = w_ok_q ? RESP_OKAY : RESP_SLVERR;
        w_state_d = W_RESP;
      end
      W_RESP: if (s_axi.s_axi_b_ready) w_state_d = W_IDLE;
      default: w_state_d = W_IDLE;
    endcase
  end

  assign s_axi.s_axi_aw_ready = live_q && (w_state_q == W_IDLE);
  assign s_axi.s_axi_w_ready  = (w_state_q == W_DATA);
  assign s_axi.s_axi_b_valid  = (w_state_q == W_RESP);
  assign s_axi.ram_wresp_o    = b_resp_q;
  assign wr_state_o           = w_state_q;

  // ---------------- read channel ----------------
  rd_state_e         r_state_q, r_state_d;
  logic [3:0]        cnt_q, cnt_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic [1:0]        r_resp_q, r_resp_d;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state_q <= R_IDLE;
      cnt_q     <= '0;
      rdata_q   <= '0;
      r_resp_q  <= RESP_OKAY;
    end else begin
      r_state_q <= r_state_d;
      cnt_q     <= cnt_d;
      rdata_q   <= rdata_d;
      r_resp_q  <= r_resp_d;
    end
  end

  // Data is captured at the AR handshake, so a same-edge write to that word is not seen.
  always_comb begin
    r_state_d = r_state_q;
    cnt_d     = cnt_q;
    rdata_d   = rdata_q;
    r_resp_d  = r_resp_q;
    case (r_state_q)
      R_IDLE: if (live_q && s_axi.s_axi_ar_valid) begin
        rdata_d   = ar_ok ? arr_rdata : '0;
        r_resp_d  = ar_ok ? RESP_OKAY : RESP_SLVERR;
        cnt_d     = 4'(RD_LAT);
        r_state_d = (RD_LAT > 0) ? R_WAIT : R_RESP;
      end
      R_WAIT: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q <= 4'd1) r_state_d = R_RESP;
      end
      R_RESP: if (s_axi.s_axi_r_ready) r_state_d = R_IDLE;
      default: r_state_d = R_IDLE;
    endcase
  end

  assign s_axi.s_axi_ar_ready = live_q && (r_state_q == R_IDLE);
  assign s_axi.s_axi_r_valid  = (r_state_q == R_RESP);
  assign s_axi.ram_rdata_o    = rdata_q;
  assign s_axi.s_axi_r_resp   = r_resp_q;
  assign rd_state_o           = r_state_q;

  ysyx_22050019_sram_array #(.DEPTH(DEPTH)) u_array (
    .clk       (clk),
    .we_i      (mem_we),
    .widx_i    (w_idx_q),
    .wdata_i   (s_axi.ram_wdata),
    .wmask_i   (s_axi.wmask),
    .ridx_i    (ar_idx),
    .rdata_o   (arr_rdata),
    .bd_we_i   (bd_we_i),
    .bd_idx_i  (bd_idx_i),
    .bd_data_i (bd_data_i)
  );

endmodule

// File: tb/tb_ysyx_22050019_axi_sram.sv
// Directed bench for the AXI SRAM responder: write/read round trips, byte masks,
// out-of-range errors, back-pressure, read/write collision and reset abort.
module tb_ysyx_22050019_axi_sram;
  import ysyx_22050019_axi_pkg::*;

  localparam int unsigned RD_LAT = 1;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        bd_we = 1'b0;
  logic [11:0] bd_idx = '0;
  logic [63:0] bd_data = '0;
  wr_state_e   wr_state;
  rd_state_e   rd_state;
  int          n_chk = 0;
  int          n_err = 0;

  ysyx_22050019_axi_sram_if bus ();

  ysyx_22050019_axi_sram #(
    .DEPTH(4096), .BASE_ADDR(32'h8000_0000), .RD_LAT(RD_LAT)
  ) dut (
    .clk(clk), .rst(rst), .s_axi(bus),
    .bd_we_i(bd_we), .bd_idx_i(bd_idx), .bd_data_i(bd_data),
    .wr_state_o(wr_state), .rd_state_o(rd_state)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic bd_load(input logic [11:0] idx, input logic [63:0] data);
    bd_we = 1'b1; bd_idx = idx; bd_data = data;
    tick();
    bd_we = 1'b0;
  endtask

  task automatic do_write(input string tag, input logic [31:0] addr, input logic [63:0] data,
                          input logic [7:0] mask, input logic [1:0] exp_resp);
    int n;
    bus.s_axi_aw_valid = 1'b1; bus.ram_waddr = addr;
    n = 0;
    while (!bus.s_axi_aw_ready && n < 20) begin tick(); n++; end
    chk({tag, "_aw_ready"}, 64'(bus.s_axi_aw_ready), 64'd1);
    tick();
    bus.s_axi_aw_valid = 1'b0;
    bus.s_axi_w_valid = 1'b1; bus.ram_wdata = data; bus.wmask = mask;
    chk({tag, "_w_ready"}, 64'(bus.s_axi_w_ready), 64'd1);
    tick();
    bus.s_axi_w_valid = 1'b0;
    chk({tag, "_b_valid"}, 64'(bus.s_axi_b_valid), 64'd1);
    chk({tag, "_b_resp"}, 64'(bus.ram_wresp_o), 64'(exp_resp));
    bus.s_axi_b_ready = 1'b1;
    tick();
    bus.s_axi_b_ready = 1'b0;
  endtask

  task automatic do_read(input string tag, input logic [31:0] addr, input logic [63:0] exp_data,
                         input logic [1:0] exp_resp, input int hold);
    int n;
    bus.s_axi_ar_valid = 1'b1; bus.ram_raddr = addr;
    n = 0;
    while (!bus.s_axi_ar_ready && n < 20) begin tick(); n++; end
    chk({tag, "_ar_ready"}, 64'(bus.s_axi_ar_ready), 64'd1);
    tick();
    bus.s_axi_ar_valid = 1'b0;
    n = 0;
    while (!bus.s_axi_r_valid && n < 30) begin tick(); n++; end
    chk({tag, "_r_lat"}, 64'(n), 64'(RD_LAT));
    chk({tag, "_r_data"}, bus.ram_rdata_o, exp_data);
    chk({tag, "_r_resp"}, 64'(bus.s_axi_r_resp), 64'(exp_resp));
    for (int h = 0; h < hold; h++) begin
      tick();
      chk({tag, "_hold_valid"}, 64'(bus.s_axi_r_valid), 64'd1);
      chk({tag, "_hold_data"}, bus.ram_rdata_o, exp_data);
      chk({tag, "_hold_resp"}, 64'(bus.s_axi_r_resp), 64'(exp_resp));
      chk({tag, "_hold_ar_ready"}, 64'(bus.s_axi_ar_ready), 64'd0);
    end
    bus.s_axi_r_ready = 1'b1;
    tick();
    bus.s_axi_r_ready = 1'b0;
  endtask

  initial begin
    bus.s_axi_aw_valid = 1'b0; bus.ram_waddr = '0;
    bus.s_axi_w_valid = 1'b0; bus.ram_wdata = '0; bus.wmask = '0;
    bus.s_axi_b_ready = 1'b0;
    bus.s_axi_ar_valid = 1'b0; bus.ram_raddr = '0;
    bus.s_axi_r_ready = 1'b0;

    // reset state
    #2;
    chk("rst_aw_ready", 64'(bus.s_axi_aw_ready), 64'd0);
    chk("rst_ar_ready", 64'(bus.s_axi_ar_ready), 64'd0);
    chk("rst_w_ready", 64'(bus.s_axi_w_ready), 64'd0);
    chk("rst_b_valid", 64'(bus.s_axi_b_valid), 64'd0);
    chk("rst_r_valid", 64'(bus.s_axi_r_valid), 64'd0);
    chk("rst_rdata", bus.ram_rdata_o, 64'd0);
    chk("rst_bresp", 64'(bus.ram_wresp_o), 64'd0);
    chk("rst_rresp", 64'(bus.s_axi_r_resp), 64'd0);

    bd_load(12'h000, 64'hDEAD_BEEF_0000_0001);
    bd_load(12'h002, 64'h0);
    bd_load(12'h004, 64'h0);
    bd_load(12'h005, 64'h0102_0304_0506_0708);
    bd_load(12'h006, 64'hCAFE_F00D_1234_5678);
    bd_load(12'hFFF, 64'h5555_AAAA_5555_AAAA);
    chk("rst_hold_aw_ready", 64'(bus.s_axi_aw_ready), 64'd0);

    rst = 1'b1;
    chk("rel_aw_ready_pre", 64'(bus.s_axi_aw_ready), 64'd0);
    tick();
    chk("rel_aw_ready", 64'(bus.s_axi_aw_ready), 64'd1);
    chk("rel_ar_ready", 64'(bus.s_axi_ar_ready), 64'd1);
    chk("idle_w_ready", 64'(bus.s_axi_w_ready), 64'd0);
    chk("idle_wr_state", 64'(wr_state), 64'(W_IDLE));

    // full-word round trip
    do_write("wr_full", 32'h8000_0010, 64'h1122_3344_5566_7788, 8'hFF, RESP_OKAY);
    do_read("rd_full", 32'h8000_0010, 64'h1122_3344_5566_7788, RESP_OKAY, 0);

    // byte strobes
    do_write("wr_b5", 32'h8000_0020, 64'h0000_AA00_0000_0000, 8'h20, RESP_OKAY);
    do_read("rd_b5", 32'h8000_0020, 64'h0000_AA00_0000_0000, RESP_OKAY, 0);
    do_write("wr_lo4", 32'h8000_002C, 64'hFFFF_FFFF_FFFF_FFFF, 8'h0F, RESP_OKAY);
    do_read("rd_lo4", 32'h8000_0028, 64'h0102_0304_FFFF_FFFF, RESP_OKAY, 0);

    // out-of-range: below base and one past the top
    do_write("wr_low_oor", 32'h7FFF_FFF8, 64'hFFFF_FFFF_FFFF_FFFF, 8'hFF, RESP_SLVERR);
    do_write("wr_high_oor", 32'h8000_8000, 64'hFFFF_FFFF_FFFF_FFFF, 8'hFF, RESP_SLVERR);
    do_read("rd_low_oor", 32'h7FFF_FFF8, 64'h0, RESP_SLVERR, 0);
    do_read("rd_high_oor", 32'h8000_8000, 64'h0, RESP_SLVERR, 0);
    do_read("rd_top_word", 32'h8000_7FF8, 64'h5555_AAAA_5555_AAAA, RESP_OKAY, 0);
    do_read("rd_word0", 32'h8000_0000, 64'hDEAD_BEEF_0000_0001, RESP_OKAY, 0);

    // back-pressure on R
    do_read("rd_hold", 32'h8000_0010, 64'h1122_3344_5566_7788, RESP_OKAY, 5);

    // AR and W handshakes on the same edge to the same word
    bus.s_axi_aw_valid = 1'b1; bus.ram_waddr = 32'h8000_0030;
    chk("col_aw_ready", 64'(bus.s_axi_aw_ready), 64'd1);
    tick();
    bus.s_axi_aw_valid = 1'b0;
    bus.s_axi_w_valid = 1'b1; bus.ram_wdata = 64'h0F0E_0D0C_0B0A_0908; bus.wmask = 8'hFF;
    bus.s_axi_ar_valid = 1'b1; bus.ram_raddr = 32'h8000_0030;
    chk("col_w_ready", 64'(bus.s_axi_w_ready), 64'd1);
    chk("col_ar_ready", 64'(bus.s_axi_ar_ready), 64'd1);
    tick();
    bus.s_axi_w_valid = 1'b0; bus.s_axi_ar_valid = 1'b0;
    chk("col_b_valid", 64'(bus.s_axi_b_valid), 64'd1);
    chk("col_b_resp", 64'(bus.ram_wresp_o), 64'(RESP_OKAY));
    chk("col_r_wait", 64'(bus.s_axi_r_valid), 64'd0);
    bus.s_axi_b_ready = 1'b1;
    tick();
    bus.s_axi_b_ready = 1'b0;
    chk("col_r_valid", 64'(bus.s_axi_r_valid), 64'd1);
    chk("col_r_old", bus.ram_rdata_o, 64'hCAFE_F00D_1234_5678);
    bus.s_axi_r_ready = 1'b1;
    tick();
    bus.s_axi_r_ready = 1'b0;
    do_read("col_r_new", 32'h8000_0030, 64'h0F0E_0D0C_0B0A_0908, RESP_OKAY, 0);

    // reset while waiting on a read
    bus.s_axi_ar_valid = 1'b1; bus.ram_raddr = 32'h8000_0010;
    tick();
    bus.s_axi_ar_valid = 1'b0;
    chk("abort_in_wait", 64'(rd_state), 64'(R_WAIT));
    rst = 1'b0;
    #1;
    chk("abort_rst_r_valid", 64'(bus.s_axi_r_valid), 64'd0);
    chk("abort_rst_ar_ready", 64'(bus.s_axi_ar_ready), 64'd0);
    tick();
    chk("abort_rst_r_valid2", 64'(bus.s_axi_r_valid), 64'd0);
    rst = 1'b1;
    tick();
    chk("abort_rel_ar_ready", 64'(bus.s_axi_ar_ready), 64'd1);
    chk("abort_rel_r_valid", 64'(bus.s_axi_r_valid), 64'd0);
    tick();
    chk("abort_late_r_valid", 64'(bus.s_axi_r_valid), 64'd0);
    do_read("abort_new_read", 32'h8000_0010, 64'h1122_3344_5566_7788, RESP_OKAY, 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/ysyx_22050019_axi_sram.md
# ysyx_22050019_axi_sram

- AXI4-Lite-style responder (slave) with a 64-bit word-organised memory behind it.
- Serves the LSU's single-beat load/store transactions on separate read and write channels: AR/R for reads, AW/W/B for writes.
- Sits between the LSU and the simulated main memory and is the memory endpoint used in the core test bench.
- Read latency is configurable; out-of-range accesses return an error response.

## Interface
Parameters:
- DEPTH, 4096 — number of 64-bit words; power of two.
- BASE_ADDR, 32'h8000_0000 — byte address of word 0.
- RD_LAT, 1 — extra wait cycles between AR handshake and r_valid; 0..15.

Ports:
- clk  in  1  — single clock, rising edge.
- rst  in  1  — reset, asynchronous, active-low.
- s_axi_aw_valid  in  1  — write address valid.
- s_axi_aw_ready  out  1  — write address ready.
- ram_waddr  in  32  — write byte address.
- s_axi_w_valid  in  1  — write data valid.
- s_axi_w_ready  out  1  — write data ready.
- ram_wdata  in  64  — write data, already lane-aligned by the master.
- wmask  in  8  — byte strobes; bit i enables byte i.
- s_axi_b_valid  out  1  — write response valid.
- s_axi_b_ready  in  1  — write response ready.
- ram_wresp_o  out  2  — write response: 00 OKAY, 10 SLVERR.
- s_axi_ar_valid  in  1  — read address valid.
- s_axi_ar_ready  out  1  — read address ready.
- ram_raddr  in  32  — read byte address.
- s_axi_r_valid  out  1  — read data valid.
- s_axi_r_ready  in  1  — read data ready.
- ram_rdata_o  out  64  — full 64-bit word; the master extracts lanes.
- s_axi_r_resp  out  2  — read response: 00 OKAY, 10 SLVERR.

## Operation
Address decode:
- off = addr − BASE_ADDR, computed in 32 bits.
- In range iff off < DEPTH*8 (unsigned).
- Word index = off[3 +: log2(DEPTH)]; addr[2:0] is ignored.

Write FSM, W_IDLE → W_DATA → W_RESP:
- W_IDLE: aw_ready=1. On aw_valid&aw_ready, latch the address and its in-range flag; go to W_DATA.
- W_DATA: w_ready=1. On w_valid:
  - If in range, write each byte whose wmask bit is set.
  - Latch the response: OKAY if in range, otherwise SLVERR with no write.
  - Go to W_RESP.
- W_RESP: b_valid=1, response held stable. On b_ready, go to W_IDLE.
- W before AW is not accepted: w_ready=0 outside W_DATA.

Read FSM, R_IDLE → R_WAIT → R_RESP:
- R_IDLE: ar_ready=1. On handshake:
  - Capture the array word, or 0 if out of range, into the read data register.
  - Capture the response.
  - Load the counter with RD_LAT.
  - Go to R_WAIT if RD_LAT>0, else R_RESP.
- R_WAIT: decrement the counter; go to R_RESP when it reaches 1.
- R_RESP: r_valid=1; data and response held stable until r_ready. On r_ready, go to R_IDLE.

Channel independence and collisions:
- Read and write channels are fully independent and may be busy simultaneously.
- If a read captures in the same cycle as a write commits to the same word, the read returns the old data.

Memory contents are not reset; initial contents come from the bench via a backdoor load.

## Timing
- All outputs are registered or decoded from state registers only; no input-to-output combinational path.
- Reset (rst=0, asynchronous):
  - Both FSMs go to IDLE.
  - All ready and valid outputs are 0; ram_rdata_o=0; both responses 00; counter=0.
  - aw_ready and ar_ready rise on the first clk edge after reset release.
- Read latency: r_valid is asserted RD_LAT+1 cycles after the AR handshake edge.
- Write latency: b_valid is asserted 1 cycle after the W handshake edge.
- Throughput:
  - Read: one transaction per RD_LAT+2 cycles with r_ready held high.
  - Write: one transaction per 3 cycles.
- The next AR or AW is not accepted until the previous response handshake completes; ready is 0 in every non-IDLE state.
- Reset asserted mid-transaction aborts it immediately:
  - A write already committed stays in memory.
  - No B or R response is ever issued for the aborted transaction.

## Structure
- Package ysyx_22050019_axi_pkg holds:
  - response codes RESP_OKAY=2'b00 and RESP_SLVERR=2'b10;
  - read and write FSM state encodings;
  - the 64-bit data and 32-bit address width constants.
- One sub-module, ysyx_22050019_sram_array:
  - DEPTH×64 storage;
  - one byte-masked synchronous write port;
  - one combinational read port;
  - a backdoor load hook for the bench.

## Test plan
- Write 0x1122334455667788 to 0x8000_0010 with wmask=0xFF; then read 0x8000_0010 with RD_LAT=1:
  - b_resp=00, one cycle after W;
  - r_valid two cycles after AR; data 0x1122334455667788.
- Word preloaded with 0; write 0xAA<<40 with wmask=0x20; read back: 0x0000AA0000000000, OKAY.
- Write to 0x7FFF_FFF8 and to BASE+DEPTH*8: both return SLVERR; memory is unchanged; a read at either address returns 0 with SLVERR.
- Hold r_ready=0 for 5 cycles after r_valid rises: r_valid, ram_rdata_o and r_resp stay stable, and ar_ready stays 0 until the R handshake.
- Read and write to the same word with the AR and W handshakes in the same cycle: the read returns the pre-write value; a subsequent read returns the new value.
- Assert rst for one cycle while in R_WAIT:
  - r_valid is never asserted for that read;
  - ar_ready=1 on the first edge after release;
  - a new read then completes normally.
